hopfield_phase_controller: RTL
==============================

Name: hopfield_phase_controller

Overview:
Sequencer for the 7-neuron Hopfield network. Accepts learn/recall commands over a valid/ready handshake and drives the network's pattern-injection and plasticity controls. After a recall cue it watches the network's spike outputs until the spike pattern settles, then returns the settled pattern, a converged flag and a cycle count over a second valid/ready handshake. Sits between the host/command logic and the hopfield_network instance.

Parameters:
LEARN_CYCLES, 64, cycles of injection with plasticity enabled for a learn command.
CUE_CYCLES, 16, cycles of cue injection with plasticity disabled before settling.
WIN_CYCLES, 8, length of one spike observation window in cycles.
STABLE_WINDOWS, 3, consecutive equal window comparisons required to declare convergence.
MAX_SETTLE, 1024, settle-cycle timeout; used only when the optional feature is compiled in.
CNT_W, 16, width of the settle cycle counter and res_cycles.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  controller can accept a command; high only in IDLE.
cmd_learn  in  1  1 = learn, 0 = recall; sampled on the handshake.
cmd_pattern  in  4  pattern to learn, or recall cue; sampled on the handshake.
abort  in  1  synchronous abort; returns to IDLE and produces no result.
net_inject  out  1  enables external pattern current into neurons 0-3.
net_learn  out  1  enables Hebbian weight update.
net_pattern  out  4  pattern presented to the network.
net_spikes  in  7  spike outputs from the network.
res_valid  out  1  result available.
res_ready  in  1  result consumed.
res_pattern  out  7  settled spike pattern (OR over the final window).
res_converged  out  1  1 = converged, 0 = timed out.
res_cycles  out  CNT_W  settle cycles used, or LEARN_CYCLES for a learn.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, LEARN, CUE, SETTLE, REPORT. While reset is asserted, state is IDLE, so cmd_ready=1. All other outputs and internal registers are 0.
- IDLE: a handshake (cmd_valid & cmd_ready) latches cmd_learn and cmd_pattern. The next state is LEARN if cmd_learn=1, otherwise CUE.
- LEARN: net_inject=1, net_learn=1, net_pattern=latched pattern, for exactly LEARN_CYCLES cycles. Then REPORT with res_pattern=0, res_converged=1, res_cycles=LEARN_CYCLES.
- CUE: net_inject=1, net_learn=0, net_pattern=latched pattern, for exactly CUE_CYCLES cycles. Then SETTLE.
- SETTLE:
  - net_inject=0, net_learn=0, net_pattern=0.
  - Settle counter increments every SETTLE cycle and saturates at 2^CNT_W-1.
  - Window accumulator ORs net_spikes each cycle.
  - On the last cycle of each window, win = accumulator | net_spikes.
  - The first window only loads prev_win and sets prev_valid.
  - Later windows: if win==prev_win, stable_cnt increments; otherwise stable_cnt clears. prev_win is updated to win, and the accumulator clears.
  - When stable_cnt reaches STABLE_WINDOWS, go to REPORT with res_pattern=win, res_converged=1, res_cycles=settle count including the current cycle.
- REPORT: res_valid=1. res_* are registered and held stable until res_ready=1, then the state returns to IDLE. cmd_valid is ignored outside IDLE.
- Outputs net_*, res_*, cmd_ready and busy are driven from registered state only; no combinational path from inputs to outputs.
- abort: in any state except IDLE, the next state is IDLE, and all counters and outputs clear. In REPORT, abort drops res_valid without a handshake. abort takes priority over every other transition, including res_ready.
- Reset mid-operation clears everything immediately. net_learn and net_inject drop asynchronously.
- STABLE_WINDOWS=0 is treated as 1.

Optional Feature:
HOPFIELD_SETTLE_TIMEOUT_EN
- Defined: when the settle count reaches MAX_SETTLE without convergence, go to REPORT with res_converged=0, res_pattern=last completed win (0 if none), res_cycles=MAX_SETTLE. If convergence and timeout occur on the same cycle, convergence wins.
- Undefined: no timeout; SETTLE exits only on convergence or abort. MAX_SETTLE is unused.

Test Plan:
(LEARN_CYCLES=4, CUE_CYCLES=2, WIN_CYCLES=4, STABLE_WINDOWS=2, MAX_SETTLE=32)
- Learn, cmd_pattern=4'b1010 -> net_inject=net_learn=1 and net_pattern=1010 for exactly 4 cycles after the handshake; then res_valid=1, res_converged=1, res_cycles=4, res_pattern=0.
- Recall, cue 4'b0101, net_spikes held at 7'b0100101 -> net_inject=1 and net_learn=0 for 2 cycles; res_valid after 12 SETTLE cycles with res_pattern=0100101, res_converged=1, res_cycles=12.
- Macro on, spikes alternating 7'h01 / 7'h02 per window -> res_converged=0, res_cycles=32, res_pattern equal to the last completed window value.
- res_ready held low 10 cycles in REPORT -> res_* stable, cmd_ready=0, busy=1, and a cmd_valid pulse is not accepted; res_ready=1 -> IDLE the next cycle.
- abort on the 3rd SETTLE cycle -> IDLE the next cycle, no res_valid; reset asserted mid-LEARN -> net_learn=0 with no clock edge, cmd_ready=1.
- Macro off, same alternating stimulus -> still in SETTLE after 100 cycles with res_valid=0; abort then returns to IDLE.

Source files
------------

// File: rtl/hopfield_phase_controller_if.sv
// Command and result handshake bundle between the host logic and hopfield_phase_controller.
interface hopfield_phase_controller_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_learn;
  logic [3:0]       cmd_pattern;
  logic             res_valid;
  logic             res_ready;
  logic [6:0]       res_pattern;
  logic             res_converged;
  logic [CNT_W-1:0] res_cycles;

  modport slave (
    input  cmd_valid, cmd_learn, cmd_pattern, res_ready,
    output cmd_ready, res_valid, res_pattern, res_converged, res_cycles
  );

  modport master (
    output cmd_valid, cmd_learn, cmd_pattern, res_ready,
    input  cmd_ready, res_valid, res_pattern, res_converged, res_cycles
  );
endinterface

// File: rtl/hopfield_phase_controller.sv
// Learn/recall sequencer for the 7-neuron Hopfield network with spike-settle detection.
// Optional settle timeout is compiled in with HOPFIELD_SETTLE_TIMEOUT_EN.
module hopfield_phase_controller #(
  parameter int LEARN_CYCLES   = 64,
  parameter int CUE_CYCLES     = 16,
  parameter int WIN_CYCLES     = 8,
  parameter int STABLE_WINDOWS = 3,
  parameter int MAX_SETTLE     = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  hopfield_phase_controller_if.slave   host,
  input  logic                         abort,
  output logic                         net_inject,
  output logic                         net_learn,
  output logic [3:0]                   net_pattern,
  input  logic [6:0]                   net_spikes,
  output logic                         busy
);

  localparam int PH_MAX = (LEARN_CYCLES > CUE_CYCLES) ? LEARN_CYCLES : CUE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WP_W   = $clog2(WIN_CYCLES + 1);
  localparam int SW_EFF = (STABLE_WINDOWS < 1) ? 1 : STABLE_WINDOWS;
  localparam int SC_W   = $clog2(SW_EFF + 1);
  localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(MAX_SETTLE);
`ifdef HOPFIELD_SETTLE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LEARN, CUE, SETTLE, REPORT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pat_q, pat_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [WP_W-1:0]  wpos_q, wpos_d;
  logic [6:0]       acc_q, acc_d;
  logic [6:0]       prev_win_q, prev_win_d;
  logic             prev_valid_q, prev_valid_d;
  logic [SC_W-1:0]  stable_q, stable_d;
  logic [6:0]       res_pattern_q, res_pattern_d;
  logic             res_conv_q, res_conv_d;
  logic [CNT_W-1:0] res_cycles_q, res_cycles_d;

  logic [CNT_W-1:0] settle_inc;
  logic [6:0]       win_now;
  logic             win_done;
  logic             conv_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      phase_q       <= '0;
      settle_q      <= '0;
      wpos_q        <= '0;
      acc_q         <= '0;
      prev_win_q    <= '0;
      prev_valid_q  <= 1'b0;
      stable_q      <= '0;
      res_pattern_q <= '0;
      res_conv_q    <= 1'b0;
      res_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      phase_q       <= phase_d;
      settle_q      <= settle_d;
      wpos_q        <= wpos_d;
      acc_q         <= acc_d;
      prev_win_q    <= prev_win_d;
      prev_valid_q  <= prev_valid_d;
      stable_q      <= stable_d;
      res_pattern_q <= res_pattern_d;
      res_conv_q    <= res_conv_d;
      res_cycles_q  <= res_cycles_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    phase_d       = phase_q;
    settle_d      = settle_q;
    wpos_d        = wpos_q;
    acc_d         = acc_q;
    prev_win_d    = prev_win_q;
    prev_valid_d  = prev_valid_q;
    stable_d      = stable_q;
    res_pattern_d = res_pattern_q;
    res_conv_d    = res_conv_q;
    res_cycles_d  = res_cycles_q;
    conv_now      = 1'b0;
    settle_inc    = (settle_q == '1) ? settle_q : settle_q + 1'b1;
    win_now       = acc_q | net_spikes;
    win_done      = (wpos_q == WP_W'(WIN_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (host.cmd_valid) begin
          pat_d   = host.cmd_pattern;
          phase_d = '0;
          state_d = host.cmd_learn ? LEARN : CUE;
        end
      end
      LEARN: begin
        if (phase_q == PH_W'(LEARN_CYCLES - 1)) begin
          phase_d       = '0;
          state_d       = REPORT;
          res_pattern_d = '0;
          res_conv_d    = 1'b1;
          res_cycles_d  = CNT_W'(LEARN_CYCLES);
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      CUE: begin
        if (phase_q == PH_W'(CUE_CYCLES - 1)) begin
          phase_d      = '0;
          state_d      = SETTLE;
          settle_d     = '0;
          wpos_d       = '0;
          acc_d        = '0;
          prev_win_d   = '0;
          prev_valid_d = 1'b0;
          stable_d     = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        settle_d = settle_inc;
        // The first completed window only seeds the comparison reference.
        if (win_done) begin
          wpos_d       = '0;
          acc_d        = '0;
          prev_win_d   = win_now;
          prev_valid_d = 1'b1;
          if (prev_valid_q) begin
            if (win_now == prev_win_q) begin
              stable_d = stable_q + 1'b1;
              conv_now = (stable_q == SC_W'(SW_EFF - 1));
            end else begin
              stable_d = '0;
            end
          end
        end else begin
          wpos_d = wpos_q + 1'b1;
          acc_d  = win_now;
        end
        if (conv_now) begin
          state_d       = REPORT;
          res_pattern_d = win_now;
          res_conv_d    = 1'b1;
          res_cycles_d  = settle_inc;
        end else if (TIMEOUT_EN && settle_inc == SETTLE_LIMIT) begin
          state_d       = REPORT;
          res_pattern_d = win_done ? win_now : prev_win_q;
          res_conv_d    = 1'b0;
          res_cycles_d  = SETTLE_LIMIT;
        end
      end
      REPORT: begin
        if (host.res_ready) begin
          state_d       = IDLE;
          res_pattern_d = '0;
          res_conv_d    = 1'b0;
          res_cycles_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition above, including the result handshake.
    if (abort && state_q != IDLE) begin
      state_d       = IDLE;
      pat_d         = '0;
      phase_d       = '0;
      settle_d      = '0;
      wpos_d        = '0;
      acc_d         = '0;
      prev_win_d    = '0;
      prev_valid_d  = 1'b0;
      stable_d      = '0;
      res_pattern_d = '0;
      res_conv_d    = 1'b0;
      res_cycles_d  = '0;
    end
  end

  assign host.cmd_ready     = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign net_inject         = (state_q == LEARN) || (state_q == CUE);
  assign net_learn          = (state_q == LEARN);
  assign net_pattern        = net_inject ? pat_q : 4'b0000;
  assign host.res_valid     = (state_q == REPORT);
  assign host.res_pattern   = res_pattern_q;
  assign host.res_converged = res_conv_q;
  assign host.res_cycles    = res_cycles_q;

endmodule
